// File: rtl/stream_word_serializer.sv
// rtl/stream_word_serializer.sv - wide-to-narrow word serializer with valid/ready on both sides
//
// Accepts one WORD_W-bit word and emits WORD_W/BEAT_W beats of BEAT_W bits,
// most-significant beat first (LSB_FIRST=0) or least-significant first (LSB_FIRST=1).
// A new word can be taken on the same cycle the last beat of the previous word
// transfers, so a continuous stream runs without bubbles.
//
// Optional feature macro: STREAM_SERIALIZER_PARITY_EN (adds out_parity).
//
// Ports:
//   clk        - clock, all state on rising edge
//   rst        - synchronous reset, active-high
//   in_valid   - input word offered
//   in_ready   - serializer accepts a word this cycle (combinational from out_ready)
//   in_data    - input word, WORD_W bits
//   out_valid  - beat on out_data is valid
//   out_ready  - downstream accepts the beat
//   out_data   - current beat, BEAT_W bits
//   out_last   - current beat is the final beat of its word
//   out_index  - emission-order index of the current beat (0 outside a word)
//   out_parity - XOR reduction of out_data (only with STREAM_SERIALIZER_PARITY_EN)

module stream_word_serializer #(
  parameter int WORD_W    = 32,
  parameter int BEAT_W    = 8,
  parameter int LSB_FIRST = 0,
  localparam int NBEATS   = WORD_W / BEAT_W,
  localparam int IDX_W    = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BEAT_W-1:0] out_data,
  output logic              out_last,
  output logic [IDX_W-1:0]  out_index
`ifdef STREAM_SERIALIZER_PARITY_EN
  ,
  output logic              out_parity
`endif
);

  generate
    if ((BEAT_W < 1) || (BEAT_W > WORD_W) || ((WORD_W % BEAT_W) != 0)) begin : g_param_check
      $error("stream_word_serializer: WORD_W must be a positive multiple of BEAT_W");
    end
  endgenerate

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t             state;
  logic [WORD_W-1:0]  word_q;
  logic [IDX_W-1:0]   cnt_q;

  logic               accept;
  logic               xfer;
  logic [IDX_W-1:0]   nxt_idx;
  logic [BEAT_W-1:0]  load_beat;
  logic [BEAT_W-1:0]  step_beat;

  // Beat `idx` in emission order; variable-base indexed part-selects pick the slice.
  function automatic logic [BEAT_W-1:0] beat_sel(input logic [WORD_W-1:0] w,
                                                 input logic [IDX_W-1:0]  idx);
    int base;
    base = int'(idx) * BEAT_W;
    if (LSB_FIRST != 0) begin
      beat_sel = w[base +: BEAT_W];
    end else begin
      beat_sel = w[WORD_W - 1 - base -: BEAT_W];
    end
  endfunction

  // out_last is only ever set in SEND, so the second term also covers the
  // back-to-back case where the final beat leaves and a new word enters.
  assign in_ready  = (state == IDLE) || (out_last && out_ready);
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;
  assign out_index = cnt_q;

  always_comb begin
    nxt_idx   = cnt_q + IDX_W'(1);
    load_beat = beat_sel(in_data, '0);
    step_beat = beat_sel(word_q, nxt_idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      word_q     <= '0;
      cnt_q      <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
`ifdef STREAM_SERIALIZER_PARITY_EN
      out_parity <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= SEND;
            word_q     <= in_data;
            cnt_q      <= '0;
            out_valid  <= 1'b1;
            out_last   <= (NBEATS == 1);
            out_data   <= load_beat;
`ifdef STREAM_SERIALIZER_PARITY_EN
            out_parity <= ^load_beat;
`endif
          end
        end
        SEND: begin
          if (accept) begin
            // Last beat leaves and the next word is loaded on the same edge.
            word_q     <= in_data;
            cnt_q      <= '0;
            out_valid  <= 1'b1;
            out_last   <= (NBEATS == 1);
            out_data   <= load_beat;
`ifdef STREAM_SERIALIZER_PARITY_EN
            out_parity <= ^load_beat;
`endif
          end else if (xfer) begin
            if (out_last) begin
              state      <= IDLE;
              cnt_q      <= '0;
              out_valid  <= 1'b0;
              out_last   <= 1'b0;
              out_data   <= '0;
`ifdef STREAM_SERIALIZER_PARITY_EN
              out_parity <= 1'b0;
`endif
            end else begin
              cnt_q      <= nxt_idx;
              out_last   <= (nxt_idx == LAST_IDX);
              out_data   <= step_beat;
`ifdef STREAM_SERIALIZER_PARITY_EN
              out_parity <= ^step_beat;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
